// File: rtl/sbox_step_sequencer.sv
// Launches one masked S-box nibble into an external step stage and returns its result.
// Define SEQ_SHARE_REFRESH_EN to re-mask both shares with fresh LFSR bits on launch.

module sbox_step_sequencer #(
    parameter  int unsigned LATENCY = 1,
    localparam int unsigned NIB_W   = 4,
    localparam int unsigned LFSR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_sh0,
    input  logic [NIB_W-1:0]  in_sh1,
    output logic [NIB_W-1:0]  stg_sh0,
    output logic [NIB_W-1:0]  stg_sh1,
    output logic [NIB_W-1:0]  stg_r,
    input  logic [NIB_W-1:0]  stg_res0,
    input  logic [NIB_W-1:0]  stg_res1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_sh0,
    output logic [NIB_W-1:0]  out_sh1,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              busy
);

    localparam int unsigned     CNT_W      = 3;
    localparam int unsigned     LFSR_STEPS = 8;
    localparam logic [LFSR_W-1:0] LFSR_RST = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NIB_W-1:0]   sh0_q, sh0_d;
    logic [NIB_W-1:0]   sh1_q, sh1_d;
    logic [NIB_W-1:0]   res0_q, res0_d;
    logic [NIB_W-1:0]   res1_q, res1_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]  lfsr_adv;
    logic [NIB_W-1:0]   mask;

    // Right-shifting Fibonacci LFSR, taps for x^16+x^14+x^13+x^11+1.
    function automatic logic [LFSR_W-1:0] lfsr_step8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int i = 0; i < int'(LFSR_STEPS); i++) begin
            v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[LFSR_W-1:1]};
        end
        return v;
    endfunction

    assign lfsr_adv = lfsr_step8(lfsr_q);

`ifdef SEQ_SHARE_REFRESH_EN
    assign mask = lfsr_adv[7:4];
`else
    assign mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            lfsr_q  <= LFSR_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            IDLE: begin
                // An accept takes precedence over a concurrent reseed.
                if (in_valid) begin
                    sh0_d   = in_sh0 ^ mask;
                    sh1_d   = in_sh1 ^ mask;
                    lfsr_d  = lfsr_adv;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = WAIT;
                end else if (seed_load) begin
                    lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res0_d  = stg_res0;
                    res1_d  = stg_res1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign stg_sh0   = sh0_q;
    assign stg_sh1   = sh1_q;
    assign stg_r     = lfsr_q[3:0];
    assign out_sh0   = res0_q;
    assign out_sh1   = res1_q;

endmodule

// File: tb/tb_sbox_step_sequencer.sv
// Directed bench for sbox_step_sequencer: one LATENCY=1 and one LATENCY=4 instance
// with pass-through stub stages fed from the registered stage shares.

module tb_sbox_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_SHARE_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    // Instance A (LATENCY=1)
    logic        rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, seed_load_a, busy_a;
    logic [3:0]  in_sh0_a, in_sh1_a, stg_sh0_a, stg_sh1_a, stg_r_a, out_sh0_a, out_sh1_a;
    logic [3:0]  stg_res0_a, stg_res1_a;
    logic [15:0] seed_a;
    // Instance B (LATENCY=4)
    logic        rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, seed_load_b, busy_b;
    logic [3:0]  in_sh0_b, in_sh1_b, stg_sh0_b, stg_sh1_b, stg_r_b, out_sh0_b, out_sh1_b;
    logic [3:0]  stg_res0_b, stg_res1_b;
    logic [15:0] seed_b;

    assign stg_res0_a = stg_sh0_a;
    assign stg_res1_a = stg_sh1_a;
    assign stg_res0_b = stg_sh0_b;
    assign stg_res1_b = stg_sh1_b;

    sbox_step_sequencer #(.LATENCY(1)) u_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_sh0(in_sh0_a), .in_sh1(in_sh1_a), .stg_sh0(stg_sh0_a), .stg_sh1(stg_sh1_a),
        .stg_r(stg_r_a), .stg_res0(stg_res0_a), .stg_res1(stg_res1_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sh0(out_sh0_a), .out_sh1(out_sh1_a),
        .seed_load(seed_load_a), .seed(seed_a), .busy(busy_a)
    );

    sbox_step_sequencer #(.LATENCY(4)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_sh0(in_sh0_b), .in_sh1(in_sh1_b), .stg_sh0(stg_sh0_b), .stg_sh1(stg_sh1_b),
        .stg_r(stg_r_b), .stg_res0(stg_res0_b), .stg_res1(stg_res1_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sh0(out_sh0_b), .out_sh1(out_sh1_b),
        .seed_load(seed_load_b), .seed(seed_b), .busy(busy_b)
    );

    int checks;
    int errors;
    logic [15:0] lfsr_a_m;
    logic [15:0] lfsr_b_m;
    logic [3:0]  hold_m;

    function automatic logic [15:0] model_adv8(input logic [15:0] s);
        logic [15:0] v;
        logic        fb;
        v = s;
        for (int i = 0; i < 8; i++) begin
            fb = v[0] ^ v[2] ^ v[3] ^ v[5];
            v  = v >> 1;
            v[15] = fb;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_mask(input logic [15:0] s);
        return REFRESH ? s[7:4] : 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        lfsr_a_m = 16'hACE1; lfsr_b_m = 16'hACE1;
        tick();
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready_a); end
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy_a); end
        checks++; if (stg_r_a !== 4'h1) begin errors++; $display("FAIL reset_stg_r got %0h exp 1", stg_r_a); end
        checks++; if ({stg_sh0_a, stg_sh1_a, out_sh0_a, out_sh1_a} !== 16'h0000) begin
            errors++; $display("FAIL reset_shares got %0h exp 0", {stg_sh0_a, stg_sh1_a, out_sh0_a, out_sh1_a}); end
        checks++; if ({in_ready_b, out_valid_b, busy_b, stg_r_b} !== 7'b100_0001) begin
            errors++; $display("FAIL reset_b_status got %0h exp 41", {in_ready_b, out_valid_b, busy_b, stg_r_b}); end
    endtask

    task automatic test_latency1();
        in_sh0_a = 4'h5; in_sh1_a = 4'hA; in_valid_a = 1'b1; out_ready_a = 1'b0;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL l1_accept_ready got %0h exp 1", in_ready_a); end
        lfsr_a_m = model_adv8(lfsr_a_m);
        hold_m   = model_mask(lfsr_a_m);
        tick();
        in_valid_a = 1'b0;
        checks++; if ({out_valid_a, busy_a, in_ready_a} !== 3'b010) begin
            errors++; $display("FAIL l1_wait_status got %0h exp 2", {out_valid_a, busy_a, in_ready_a}); end
        checks++; if (stg_r_a !== lfsr_a_m[3:0]) begin errors++; $display("FAIL l1_stg_r got %0h exp %0h", stg_r_a, lfsr_a_m[3:0]); end
        // 0xACE1 advanced eight steps is 0x22AC.
        checks++; if (stg_r_a !== 4'hC) begin errors++; $display("FAIL l1_stg_r_hand got %0h exp c", stg_r_a); end
        checks++; if (stg_sh0_a !== (4'h5 ^ hold_m)) begin errors++; $display("FAIL l1_stg_sh0 got %0h exp %0h", stg_sh0_a, 4'h5 ^ hold_m); end
        checks++; if (stg_sh1_a !== (4'hA ^ hold_m)) begin errors++; $display("FAIL l1_stg_sh1 got %0h exp %0h", stg_sh1_a, 4'hA ^ hold_m); end
        tick();
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL l1_out_valid_t2 got %0h exp 1", out_valid_a); end
        checks++; if ((out_sh0_a ^ out_sh1_a) !== 4'hF) begin errors++; $display("FAIL l1_unmasked got %0h exp f", out_sh0_a ^ out_sh1_a); end
        checks++; if (out_sh0_a !== (4'h5 ^ hold_m)) begin errors++; $display("FAIL l1_out_sh0 got %0h exp %0h", out_sh0_a, 4'h5 ^ hold_m); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid_a, in_ready_a} !== 2'b10) begin
                errors++; $display("FAIL hold_status cyc %0d got %0h exp 2", i, {out_valid_a, in_ready_a}); end
            checks++; if ({out_sh0_a, out_sh1_a, stg_sh0_a, stg_sh1_a} !== {4'h5 ^ hold_m, 4'hA ^ hold_m, 4'h5 ^ hold_m, 4'hA ^ hold_m}) begin
                errors++; $display("FAIL hold_shares cyc %0d got %0h", i, {out_sh0_a, out_sh1_a, stg_sh0_a, stg_sh1_a}); end
            tick();
        end
        out_ready_a = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL hold_release_ready got %0h exp 0", in_ready_a); end
        tick();
        out_ready_a = 1'b0;
        checks++; if ({out_valid_a, in_ready_a, busy_a} !== 3'b010) begin
            errors++; $display("FAIL hold_exit_status got %0h exp 2", {out_valid_a, in_ready_a, busy_a}); end
    endtask

    task automatic test_seed();
        seed_load_a = 1'b1; seed_a = 16'h0000;
        tick();
        seed_load_a = 1'b0;
        lfsr_a_m = 16'h0001;
        checks++; if (stg_r_a !== 4'h1) begin errors++; $display("FAIL seed_zero_r got %0h exp 1", stg_r_a); end
        in_sh0_a = 4'h3; in_sh1_a = 4'h6; in_valid_a = 1'b1;
        lfsr_a_m = model_adv8(lfsr_a_m);
        tick();
        in_valid_a = 1'b0;
        checks++; if (stg_r_a !== lfsr_a_m[3:0]) begin errors++; $display("FAIL seed_accept_r got %0h exp %0h", stg_r_a, lfsr_a_m[3:0]); end
        // Reseed requests while busy are dropped.
        seed_load_a = 1'b1; seed_a = 16'h1234;
        tick();
        checks++; if (stg_r_a !== lfsr_a_m[3:0]) begin errors++; $display("FAIL seed_wait_ignored got %0h exp %0h", stg_r_a, lfsr_a_m[3:0]); end
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0; seed_load_a = 1'b0;
        checks++; if ({in_ready_a, stg_r_a} !== {1'b1, lfsr_a_m[3:0]}) begin
            errors++; $display("FAIL seed_hold_ignored got %0h exp %0h", {in_ready_a, stg_r_a}, {1'b1, lfsr_a_m[3:0]}); end
        in_sh0_a = 4'h1; in_sh1_a = 4'h2; in_valid_a = 1'b1; seed_load_a = 1'b1; seed_a = 16'hFFFF;
        lfsr_a_m = model_adv8(lfsr_a_m);
        tick();
        in_valid_a = 1'b0; seed_load_a = 1'b0;
        checks++; if (stg_r_a !== lfsr_a_m[3:0]) begin errors++; $display("FAIL seed_accept_wins got %0h exp %0h", stg_r_a, lfsr_a_m[3:0]); end
        checks++; if (stg_sh0_a !== (4'h1 ^ model_mask(lfsr_a_m))) begin
            errors++; $display("FAIL seed_accept_sh0 got %0h exp %0h", stg_sh0_a, 4'h1 ^ model_mask(lfsr_a_m)); end
        tick();
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        checks++; if ({out_valid_a, in_ready_a} !== 2'b01) begin errors++; $display("FAIL seed_drain got %0h exp 1", {out_valid_a, in_ready_a}); end
    endtask

    task automatic test_latency4();
        in_sh0_b = 4'h9; in_sh1_b = 4'h6; in_valid_b = 1'b1; out_ready_b = 1'b0;
        lfsr_b_m = model_adv8(lfsr_b_m);
        tick();
        in_valid_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++; if ({out_valid_b, busy_b} !== 2'b01) begin
                errors++; $display("FAIL l4_wait cyc %0d got %0h exp 1", i, {out_valid_b, busy_b}); end
            tick();
        end
        checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL l4_out_valid_t5 got %0h exp 1", out_valid_b); end
        checks++; if ((out_sh0_b ^ out_sh1_b) !== 4'hF) begin errors++; $display("FAIL l4_unmasked got %0h exp f", out_sh0_b ^ out_sh1_b); end
        checks++; if (stg_r_b !== lfsr_b_m[3:0]) begin errors++; $display("FAIL l4_stg_r got %0h exp %0h", stg_r_b, lfsr_b_m[3:0]); end
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL l4_exit_ready got %0h exp 1", in_ready_b); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        in_sh0_b = 4'h4; in_sh1_b = 4'hB; in_valid_b = 1'b1; out_ready_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        lfsr_b_m = 16'hACE1;
        checks++; if ({in_ready_b, out_valid_b, busy_b} !== 3'b100) begin
            errors++; $display("FAIL abort_status got %0h exp 4", {in_ready_b, out_valid_b, busy_b}); end
        checks++; if ({stg_r_b, stg_sh0_b, stg_sh1_b} !== 12'h100) begin
            errors++; $display("FAIL abort_regs got %0h exp 100", {stg_r_b, stg_sh0_b, stg_sh1_b}); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_b) seen = 1'b1;
            tick();
        end
        out_ready_b = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_out_valid got %0h exp 0", seen); end
    endtask

    task automatic test_back_to_back();
        int acc_a[16];
        int acc_b[16];
        int na, nb;
        bit pend_a, pend_b;
        na = 0; nb = 0; pend_a = 1'b0; pend_b = 1'b0;
        in_sh0_a = 4'h7; in_sh1_a = 4'h8; in_sh0_b = 4'hC; in_sh1_b = 4'h3;
        in_valid_a = 1'b1; in_valid_b = 1'b1; out_ready_a = 1'b1; out_ready_b = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (pend_a) begin
                checks++; if (stg_r_a !== lfsr_a_m[3:0]) begin errors++; $display("FAIL b2b_a_stg_r cyc %0d got %0h exp %0h", cyc, stg_r_a, lfsr_a_m[3:0]); end
            end
            if (pend_b) begin
                checks++; if (stg_r_b !== lfsr_b_m[3:0]) begin errors++; $display("FAIL b2b_b_stg_r cyc %0d got %0h exp %0h", cyc, stg_r_b, lfsr_b_m[3:0]); end
            end
            pend_a = 1'b0; pend_b = 1'b0;
            if (in_ready_a && na < 16) begin
                acc_a[na] = cyc; na++; lfsr_a_m = model_adv8(lfsr_a_m); pend_a = 1'b1;
            end
            if (in_ready_b && nb < 16) begin
                acc_b[nb] = cyc; nb++; lfsr_b_m = model_adv8(lfsr_b_m); pend_b = 1'b1;
            end
            tick();
        end
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        checks++; if (na < 4) begin errors++; $display("FAIL b2b_a_count got %0d exp >=4", na); end
        checks++; if (nb < 3) begin errors++; $display("FAIL b2b_b_count got %0d exp >=3", nb); end
        for (int i = 1; i < na; i++) begin
            checks++; if (acc_a[i] - acc_a[i-1] != 3) begin errors++; $display("FAIL b2b_a_spacing %0d got %0d exp 3", i, acc_a[i] - acc_a[i-1]); end
        end
        for (int i = 1; i < nb; i++) begin
            checks++; if (acc_b[i] - acc_b[i-1] != 6) begin errors++; $display("FAIL b2b_b_spacing %0d got %0d exp 6", i, acc_b[i] - acc_b[i-1]); end
        end
        for (int i = 0; i < 8; i++) tick();
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL b2b_drain got %0h exp 0", {busy_a, busy_b}); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b0; seed_load_a = 1'b0; seed_a = '0; in_sh0_a = '0; in_sh1_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; seed_load_b = 1'b0; seed_b = '0; in_sh0_b = '0; in_sh1_b = '0;
        lfsr_a_m = 16'hACE1; lfsr_b_m = 16'hACE1; hold_m = '0;
        test_reset();
        test_latency1();
        test_hold_stall();
        test_seed();
        test_latency4();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_step_sequencer.md
SBOX_STEP_SEQUENCER -- requirements
Module: sbox_step_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning the cycle latency of the downstream masked step stage (legal 1..4).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock (all state on rising edge).
REQ-003 SHALL have port rst, input, 1, meaning the synchronous, active-high reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1), meaning the upstream handshake.
REQ-005 SHALL have ports in_sh0 and in_sh1 (input, 4 each), meaning share 0 and share 1 of the incoming S-box nibble.
REQ-006 SHALL have ports stg_sh0 and stg_sh1 (output, 4 each), meaning the shares driven into the step stage.
REQ-007 SHALL have port stg_r (output, 4), meaning fresh gadget randomness for the step stage.
REQ-008 SHALL have ports stg_res0 and stg_res1 (input, 4 each), meaning the result shares returned by the step stage.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), meaning the downstream handshake.
REQ-010 SHALL have ports out_sh0 and out_sh1 (output, 4 each), meaning the registered result shares.
REQ-011 SHALL have ports seed_load (input, 1) and seed (input, 16), meaning the PRNG reseed request.
REQ-012 SHALL have port busy (output, 1), meaning high whenever the state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM (IDLE, WAIT, HOLD) with one transaction in flight at most.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready SHALL register shares into stg_sh0/stg_sh1, advance the PRNG, load counter=LATENCY, and go to WAIT.
REQ-015 WAIT: in_ready=0; counter SHALL decrement each cycle; when counter==1, SHALL capture stg_res0/stg_res1 into out_sh0/out_sh1 and go to HOLD.
REQ-016 Accept at cycle T SHALL therefore yield out_valid=1 at cycle T+LATENCY+1.
REQ-017 HOLD: out_valid=1; out_sh0/out_sh1 SHALL remain stable until out_valid&out_ready, then return to IDLE (out_valid=0 next cycle).
REQ-018 in_ready SHALL be 0 in HOLD, even if out_ready=1 that cycle; the next accept is no earlier than the following cycle.
REQ-019 stg_sh0, stg_sh1 and stg_r SHALL remain constant from the launch cycle through the HOLD exit.
REQ-020 Share 0 and share 1 SHALL sit in separate registers and never be combined within this block.
REQ-021 PRNG: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing 8 steps per accept; stg_r=state[3:0] after the advance.
REQ-022 seed_load SHALL be honoured only in IDLE without a simultaneous accept; otherwise it SHALL be ignored.
REQ-023 A seed value of 16'h0000 SHALL load 16'h0001.
REQ-024 If seed_load and an accept occur in the same IDLE cycle, the accept SHALL win and the seed is dropped.

Reset
REQ-025 On rst: state=IDLE, counter=0, and stg_sh0, stg_sh1, out_sh0, out_sh1 all =0.
REQ-026 On rst: LFSR=16'hACE1, so stg_r=4'h1, out_valid=0, in_ready=1, busy=0.
REQ-027 rst asserted in WAIT or HOLD SHALL abort the transaction; no out_valid follows.

Configuration
REQ-028 Macro SEQ_SHARE_REFRESH_EN defined: launch SHALL register in_sh0^m and in_sh1^m, with m=LFSR state[7:4] after the advance.
REQ-029 SEQ_SHARE_REFRESH_EN undefined: shares SHALL pass unmodified; LFSR stepping and latency SHALL be identical in both builds.

Verification
REQ-030 Reset release -> in_ready=1, out_valid=0, busy=0, stg_r=4'h1, all share outputs 4'h0.
REQ-031 LATENCY=1, stub stage returns stg_sh registered, accept sh0=4'h5 sh1=4'hA at T -> out_valid at T+2, out_sh0^out_sh1=4'hF (both builds).
REQ-032 out_ready held 0 for 5 cycles in HOLD -> out_valid and out_sh stable, in_ready=0 throughout; release -> IDLE the next cycle.
REQ-033 seed_load with seed=16'h0000 in IDLE, then accept -> stg_r matches the model LFSR seeded with 16'h0001 after 8 steps.
REQ-034 LATENCY=4, rst pulsed at T+2 after accept -> no out_valid, in_ready=1 at T+3, LFSR=16'hACE1.
REQ-035 Back-to-back in_valid held high -> accepts spaced exactly LATENCY+2 cycles apart with out_ready tied 1.
